// File: rtl/ebr_mem_ctrl.sv
// CPU/loader front end for a single-port EBR: 1-cycle word stores, 2-stall loads, RMW sub-word stores.
// Optional memory-mapped LED register at LED_ADDR, enabled by defining EBR_MEM_CTRL_LED_EN.
module ebr_mem_ctrl #(
  parameter logic [31:0] LED_ADDR = 32'h2000,
  parameter int unsigned AW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic          cpu_memread,
  input  logic          cpu_memwrite,
  input  logic [3:0]    cpu_sign_mask,
  output logic [31:0]   cpu_rdata,
  output logic          clk_stall,
  input  logic          ldr_valid,
  output logic          ldr_ready,
  input  logic [AW-1:0] ldr_addr,
  input  logic [31:0]   ldr_wdata,
  output logic [AW-1:0] ebr_addr,
  output logic [31:0]   ebr_wdata,
  output logic          ebr_re,
  output logic          ebr_we,
  input  logic [31:0]   ebr_rdata,
  output logic [7:0]    led
);

  typedef enum logic [1:0] {StIdle, StRead, StMerge, StDone} state_e;

  state_e        r_state, w_state_next;
  logic [AW-1:0] r_addr;
  logic [1:0]    r_off;
  logic          r_sign, r_word, r_half, r_is_wr;
  logic [15:0]   r_wdata;
  logic [31:0]   r_merged, r_rdata;

  logic          w_idle, w_wr_req, w_rd_req, w_led_hit, w_unused;
  logic          w_ebr_rd, w_ebr_rmw, w_ebr_sw, w_led_rd, w_ldr_fire;
  logic [AW-1:0] w_cpu_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load_val, w_merge_val;

  // A simultaneous read+write request is a write.
  assign w_idle     = (r_state == StIdle);
  assign w_cpu_word = cpu_addr[AW+1:2];
  assign w_wr_req   = cpu_memwrite;
  assign w_rd_req   = cpu_memread & ~cpu_memwrite;
  assign w_ebr_sw   = w_idle & w_wr_req & ~w_led_hit & cpu_sign_mask[2];
  assign w_ebr_rmw  = w_idle & w_wr_req & ~w_led_hit & ~cpu_sign_mask[2];
  assign w_ebr_rd   = w_idle & w_rd_req & ~w_led_hit;
  assign w_led_rd   = w_idle & w_rd_req & w_led_hit;
  assign ldr_ready  = ~rst & w_idle & ~cpu_memread & ~cpu_memwrite;
  assign w_ldr_fire = ldr_valid & ldr_ready;
  assign cpu_rdata  = r_rdata;

  always_comb begin
    w_byte = ebr_rdata[{r_off, 3'b000} +: 8];
    w_half = ebr_rdata[{r_off[1], 4'b0000} +: 16];
    if (r_word) begin
      w_load_val = ebr_rdata;
    end else if (r_half) begin
      w_load_val = {{16{r_sign & w_half[15]}}, w_half};
    end else begin
      w_load_val = {{24{r_sign & w_byte[7]}}, w_byte};
    end
    w_merge_val = ebr_rdata;
    if (r_half) begin
      w_merge_val[{r_off[1], 4'b0000} +: 16] = r_wdata;
    end else begin
      w_merge_val[{r_off, 3'b000} +: 8] = r_wdata[7:0];
    end
  end

  always_comb begin
    w_state_next = r_state;
    clk_stall    = 1'b0;
    ebr_re       = 1'b0;
    ebr_we       = 1'b0;
    ebr_addr     = w_cpu_word;
    ebr_wdata    = cpu_wdata;
    unique case (r_state)
      StIdle: begin
        if (w_ebr_rd | w_ebr_rmw) begin
          ebr_re       = 1'b1;
          clk_stall    = 1'b1;
          w_state_next = StRead;
        end else if (w_ebr_sw) begin
          ebr_we = 1'b1;
        end else if (w_led_rd) begin
          w_state_next = StDone;
        end else if (w_ldr_fire) begin
          ebr_we    = 1'b1;
          ebr_addr  = ldr_addr;
          ebr_wdata = ldr_wdata;
        end
      end
      StRead: begin
        clk_stall    = 1'b1;
        w_state_next = r_is_wr ? StMerge : StDone;
      end
      StMerge: begin
        clk_stall    = 1'b1;
        ebr_we       = 1'b1;
        ebr_addr     = r_addr;
        ebr_wdata    = r_merged;
        w_state_next = StDone;
      end
      StDone: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    // Reset kills any in-flight strobe, so an interrupted RMW never writes.
    if (rst) begin
      clk_stall = 1'b0;
      ebr_re    = 1'b0;
      ebr_we    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_rdata  <= '0;
      r_addr   <= '0;
      r_off    <= '0;
      r_sign   <= 1'b0;
      r_word   <= 1'b0;
      r_half   <= 1'b0;
      r_is_wr  <= 1'b0;
      r_wdata  <= '0;
      r_merged <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_ebr_rd | w_ebr_rmw) begin
        r_addr  <= w_cpu_word;
        r_off   <= cpu_addr[1:0];
        r_sign  <= cpu_sign_mask[3];
        r_word  <= cpu_sign_mask[2];
        r_half  <= cpu_sign_mask[1];
        r_is_wr <= w_wr_req;
        r_wdata <= cpu_wdata[15:0];
      end
      if (r_state == StRead) begin
        if (r_is_wr) begin
          r_merged <= w_merge_val;
        end else begin
          r_rdata <= w_load_val;
        end
      end
      if (w_led_rd) begin
        r_rdata <= {24'd0, led};
      end
    end
  end

`ifdef EBR_MEM_CTRL_LED_EN
  logic [7:0] r_led;

  assign w_led_hit = (cpu_addr == LED_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led <= '0;
    end else if (w_idle & w_wr_req & w_led_hit) begin
      r_led <= cpu_wdata[7:0];
    end
  end

  assign led      = r_led;
  assign w_unused = cpu_sign_mask[0];
`else
  assign w_led_hit = 1'b0;
  assign led       = '0;
  assign w_unused  = ^{cpu_sign_mask[0], cpu_addr[31:AW+2], LED_ADDR};
`endif

endmodule

// File: tb/tb_ebr_mem_ctrl.sv
// Self-checking bench for ebr_mem_ctrl: transaction-level memory model, EBR write/read scoreboards,
// directed literal cases and randomized CPU/loader traffic.
module tb_ebr_mem_ctrl;
  localparam int unsigned AW       = 10;
  localparam logic [31:0] LED_ADDR = 32'h2000;
`ifdef EBR_MEM_CTRL_LED_EN
  localparam bit LED_EN = 1'b1;
`else
  localparam bit LED_EN = 1'b0;
`endif

  logic          clk, rst;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_memread, cpu_memwrite, clk_stall;
  logic [3:0]    cpu_sign_mask;
  logic          ldr_valid, ldr_ready;
  logic [AW-1:0] ldr_addr, ebr_addr;
  logic [31:0]   ldr_wdata, ebr_wdata, ebr_rdata;
  logic          ebr_re, ebr_we;
  logic [7:0]    led;

  ebr_mem_ctrl #(.LED_ADDR(LED_ADDR), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_memread(cpu_memread),
    .cpu_memwrite(cpu_memwrite), .cpu_sign_mask(cpu_sign_mask), .cpu_rdata(cpu_rdata),
    .clk_stall(clk_stall), .ldr_valid(ldr_valid), .ldr_ready(ldr_ready), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ebr_addr(ebr_addr), .ebr_wdata(ebr_wdata), .ebr_re(ebr_re),
    .ebr_we(ebr_we), .ebr_rdata(ebr_rdata), .led(led)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, n_wr = 0, n_rd = 0, re_cyc = 0, we_cyc = 0;
  logic [AW-1:0] last_wa;
  logic [31:0]   last_wd;
  logic [31:0]   ebr_mem [1 << AW];
  logic [31:0]   ref_mem [1 << AW];
  logic [AW-1:0] exp_ra_q[$];
  logic [AW-1:0] exp_wa_q[$];
  logic [31:0]   exp_wd_q[$];
  logic [31:0]   ref_rdata;
  logic [7:0]    ref_led;
  logic [3:0]    masks [6];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // EBR behaviour: registered read data one cycle after ebr_re.
  always @(posedge clk) begin
    if (ebr_we) ebr_mem[ebr_addr] <= ebr_wdata;
    if (ebr_re) ebr_rdata <= ebr_mem[ebr_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] off,
                                             input logic [3:0] m);
    logic [31:0] v;
    if (m[2:0] == 3'b111) return word;
    if (m[2:0] == 3'b011) begin
      v = (word >> (off[1] ? 16 : 0)) & 32'h0000_FFFF;
      if (m[3] && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = (word >> (8 * int'(off))) & 32'h0000_00FF;
      if (m[3] && v[7]) v = v | 32'hFFFF_FF00;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] off,
                                              input logic [31:0] d, input logic [3:0] m);
    int sh;
    logic [31:0] keep;
    if (m[2:0] == 3'b111) return d;
    if (m[2:0] == 3'b011) begin
      sh = off[1] ? 16 : 0;
      keep = 32'h0000_FFFF;
    end else begin
      sh = 8 * int'(off);
      keep = 32'h0000_00FF;
    end
    return (old & ~(keep << sh)) | ((d & keep) << sh);
  endfunction

  // Per-cycle compare: every EBR strobe must match the next access the model predicted.
  always @(negedge clk) begin
    logic [AW-1:0] ea;
    logic [31:0]   ed;
    check("re_we_overlap", 32'(ebr_re & ebr_we), 32'd0);
    if (ebr_we) begin
      n_wr++; last_wa = ebr_addr; last_wd = ebr_wdata; we_cyc = cyc;
      if (exp_wa_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_we: got addr %h data %h, want no write", ebr_addr, ebr_wdata);
      end else begin
        ea = exp_wa_q.pop_front(); ed = exp_wd_q.pop_front();
        check("we_addr", 32'(ebr_addr), 32'(ea));
        check("we_data", ebr_wdata, ed);
      end
    end
    if (ebr_re) begin
      n_rd++; re_cyc = cyc;
      if (exp_ra_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_re: got addr %h, want no read", ebr_addr);
      end else begin
        ea = exp_ra_q.pop_front();
        check("re_addr", 32'(ebr_addr), 32'(ea));
      end
    end
  end

  task automatic cpu_op(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, output logic [31:0] got_rd, output int got_st);
    logic [AW-1:0] w;
    bit            led_hit, sub;
    int            exp_st;
    logic [31:0]   nv;
    w = a[AW+1:2];
    led_hit = LED_EN && (a == LED_ADDR);
    sub = (m[2:0] != 3'b111);
    exp_st = 0;
    if (wr) begin
      if (led_hit) ref_led = d[7:0];
      else begin
        nv = model_store(ref_mem[w], a[1:0], d, m);
        if (sub) begin exp_ra_q.push_back(w); exp_st = 3; end
        exp_wa_q.push_back(w); exp_wd_q.push_back(nv); ref_mem[w] = nv;
      end
    end else if (rd) begin
      if (led_hit) ref_rdata = {24'd0, ref_led};
      else begin
        ref_rdata = model_load(ref_mem[w], a[1:0], m);
        exp_ra_q.push_back(w); exp_st = 2;
      end
    end
    @(posedge clk); #1;
    cpu_addr = a; cpu_wdata = d; cpu_memread = rd; cpu_memwrite = wr; cpu_sign_mask = m;
    got_st = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (!clk_stall) break;
      got_st++;
    end
    check("stall_cycles", 32'(got_st), 32'(exp_st));
    if (rd && !wr && !led_hit) check("load_data", cpu_rdata, ref_rdata);
    got_rd = cpu_rdata;
    @(posedge clk); #1;
    cpu_memread = 1'b0; cpu_memwrite = 1'b0;
    @(negedge clk);
    check("rdata_after", cpu_rdata, ref_rdata);
    check("led", 32'(led), 32'(ref_led));
    if (rd && !wr && led_hit) got_rd = cpu_rdata;
  endtask

  task automatic ldr_write(input logic [AW-1:0] a, input logic [31:0] d);
    bit ok;
    exp_wa_q.push_back(a); exp_wd_q.push_back(d); ref_mem[a] = d;
    @(posedge clk); #1;
    ldr_valid = 1'b1; ldr_addr = a; ldr_wdata = d;
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ldr_ready) begin ok = 1'b1; break; end
    end
    check("ldr_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    ldr_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, r, d, a, exp_lw;
    logic [3:0]  m;
    int          st, c0, kind;
    masks[0] = 4'b0001; masks[1] = 4'b1001; masks[2] = 4'b0011;
    masks[3] = 4'b1011; masks[4] = 4'b0111; masks[5] = 4'b1111;
    rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_memread = 1'b0; cpu_memwrite = 1'b0;
    cpu_sign_mask = '0; ldr_valid = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) begin ebr_mem[i] = '0; ref_mem[i] = '0; end
    ref_rdata = '0; ref_led = '0;

    repeat (2) @(negedge clk);
    check("rst_stall", 32'(clk_stall), 32'd0);
    check("rst_re", 32'(ebr_re), 32'd0);
    check("rst_we", 32'(ebr_we), 32'd0);
    check("rst_ldr_ready", 32'(ldr_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("idle_ldr_ready", 32'(ldr_ready), 32'd1);

    // Literal cases on word 5 = 8091A2B3.
    ldr_write(10'd5, 32'h8091A2B3);
    cpu_op(1'b1, 1'b0, 32'h16, 32'h0, 4'b1001, rd, st);
    check("lb_lit", rd, 32'hFFFFFF91);
    check("lb_stall_lit", 32'(st), 32'd2);
    cpu_op(1'b1, 1'b0, 32'h16, 32'h0, 4'b0001, rd, st);
    check("lbu_lit", rd, 32'h00000091);
    cpu_op(1'b0, 1'b1, 32'h16, 32'h00001234, 4'b0011, rd, st);
    check("sh_stall_lit", 32'(st), 32'd3);
    check("sh_data_lit", last_wd, 32'h1234A2B3);
    check("sh_addr_lit", 32'(last_wa), 32'd5);
    check("sh_re_to_we", 32'(we_cyc - re_cyc), 32'd2);
    cpu_op(1'b1, 1'b0, 32'h17, 32'h0, 4'b0111, rd, st);
    check("lw_ignore_lsb_lit", rd, 32'h1234A2B3);
    cpu_op(1'b1, 1'b0, 32'h15, 32'h0, 4'b1011, rd, st);
    check("lh_lit", rd, 32'hFFFFA2B3);
    c0 = n_rd;
    cpu_op(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 4'b0111, rd, st);
    check("sw_stall_lit", 32'(st), 32'd0);
    check("sw_addr_lit", 32'(last_wa), 32'd8);
    check("sw_data_lit", last_wd, 32'hDEADBEEF);
    check("sw_no_read", 32'(n_rd - c0), 32'd0);
    cpu_op(1'b1, 1'b1, 32'h24, 32'h11223344, 4'b0111, rd, st);
    check("rw_is_write_lit", 32'(last_wa), 32'd9);

    c0 = n_wr;
    cpu_op(1'b0, 1'b1, 32'h2000, 32'h000000A5, 4'b0111, rd, st);
    if (LED_EN) begin
      check("led_store_lit", 32'(led), 32'hA5);
      check("led_no_we", 32'(n_wr - c0), 32'd0);
      cpu_op(1'b1, 1'b0, 32'h2000, 32'h0, 4'b0111, rd, st);
      check("led_load_lit", rd, 32'h000000A5);
    end else begin
      check("led_addr_word0", 32'(last_wa), 32'd0);
      check("led_addr_data", last_wd, 32'hA5);
      check("led_tied_lit", 32'(led), 32'd0);
    end

    // Loader held across a CPU load must wait for an idle bus.
    exp_lw = ref_mem[7];
    exp_ra_q.push_back(10'd7);
    exp_wa_q.push_back(10'd10); exp_wd_q.push_back(32'hCAFE0010); ref_mem[10] = 32'hCAFE0010;
    @(posedge clk); #1;
    cpu_addr = 32'h1C; cpu_memread = 1'b1; cpu_sign_mask = 4'b0111;
    ldr_valid = 1'b1; ldr_addr = 10'd10; ldr_wdata = 32'hCAFE0010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ldr_ready_busy", 32'(ldr_ready), 32'd0);
      check("ldr_no_we_busy", 32'(ebr_we), 32'd0);
    end
    check("lw_under_ldr", cpu_rdata, exp_lw);
    ref_rdata = exp_lw;
    @(posedge clk); #1 cpu_memread = 1'b0;
    @(negedge clk);
    check("ldr_ready_free", 32'(ldr_ready), 32'd1);
    check("ldr_we_free", 32'(ebr_we), 32'd1);
    @(posedge clk); #1 ldr_valid = 1'b0;

    // Reset in the READ cycle of an sb abandons the write.
    exp_ra_q.push_back(10'd3);
    @(posedge clk); #1;
    cpu_addr = 32'h0D; cpu_wdata = 32'h5A; cpu_memwrite = 1'b1; cpu_sign_mask = 4'b0001;
    @(negedge clk);
    check("sb_stall_idle", 32'(clk_stall), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; cpu_memwrite = 1'b0;
    @(negedge clk);
    check("rst_mid_we", 32'(ebr_we), 32'd0);
    check("rst_mid_ldr_ready", 32'(ldr_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    ref_rdata = '0; ref_led = '0;
    check("post_rst_rdata", cpu_rdata, 32'd0);
    check("post_rst_led", 32'(led), 32'd0);
    check("post_rst_stall", 32'(clk_stall), 32'd0);
    check("post_rst_re", 32'(ebr_re), 32'd0);
    check("post_rst_we", 32'(ebr_we), 32'd0);

    // Randomized traffic over a small window of words to force reuse.
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      ldr_write(AW'(i), d);
    end
    for (int t = 0; t < 240; t++) begin
      r = $urandom; d = $urandom;
      kind = int'($urandom_range(0, 9));
      m = masks[$urandom_range(0, 5)];
      a = {26'd0, r[5:0]};
      case (kind)
        0, 1, 2, 3: cpu_op(1'b1, 1'b0, a, d, m, rd, st);
        4, 5, 6, 7: cpu_op(1'b0, 1'b1, a, d, m, rd, st);
        8:          cpu_op(1'b1, 1'b1, a, d, m, rd, st);
        default:    ldr_write({6'd0, r[9:6]}, d);
      endcase
    end

    repeat (2) @(negedge clk);
    for (int i = 0; i < 32; i++) check("mem_word", ebr_mem[i], ref_mem[i]);
    check("reads_left", 32'(exp_ra_q.size()), 32'd0);
    check("writes_left", 32'(exp_wa_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ebr_mem_ctrl.md
EBR_MEM_CTRL -- requirements
Module: ebr_mem_ctrl

Interface
REQ-001 SHALL have parameter LED_ADDR, default 32'h2000, byte address of the LED register.
REQ-002 SHALL have parameter AW, default 10, EBR word-address width.
REQ-003 SHALL have one clock and a synchronous, active-high reset; ports in this order: clk in 1 (sole clock, all state on posedge); rst in 1 (synchronous, active-high reset).
REQ-004 SHALL have CPU ports:
- cpu_addr in 32: byte address.
- cpu_wdata in 32: store data.
- cpu_memread in 1: load request.
- cpu_memwrite in 1: store request.
- cpu_sign_mask in 4: [3] sign-extend, [2:0] 3'b001 byte / 3'b011 half / 3'b111 word.
- cpu_rdata out 32: load result.
- clk_stall out 1: CPU hold.
REQ-005 SHALL have loader ports:
- ldr_valid in 1: loader word-write request.
- ldr_ready out 1: loader accepted.
- ldr_addr in AW: word index.
- ldr_wdata in 32: write data.
REQ-006 SHALL have EBR ports:
- ebr_addr out AW: word address.
- ebr_wdata out 32: write word.
- ebr_re out 1: read enable.
- ebr_we out 1: write enable.
- ebr_rdata in 32: read data, valid exactly 1 cycle after ebr_re.
REQ-007 SHALL have led out 8: LED register bits [7:0].

Function
REQ-008 SHALL implement FSM states IDLE, READ, MERGE, DONE.
REQ-009 SHALL sample CPU requests only in IDLE; if cpu_memread and cpu_memwrite are both high, the access SHALL be treated as a write.
REQ-010 SHALL decode the EBR word address as cpu_addr[AW+1:2].
REQ-011 SHALL ignore cpu_addr[1:0] for word accesses and cpu_addr[0] for halfword accesses.
REQ-012 SHALL drive clk_stall combinationally high in IDLE when an EBR load or sub-word store is presented, and in READ and MERGE; it SHALL be low in DONE and otherwise.
REQ-013 Load path SHALL be IDLE (ebr_re=1, latch addr and mask) -> READ (extract byte/half/word, sign- or zero-extend per mask[3], register into cpu_rdata) -> DONE -> IDLE.
REQ-014 Loads SHALL stall exactly 2 cycles; cpu_rdata SHALL be valid in DONE and held until the next load completes.
REQ-015 A word store SHALL complete in IDLE in one cycle: ebr_we=1, ebr_wdata=cpu_wdata, no stall, state stays IDLE.
REQ-016 A sub-word store SHALL run read-modify-write: IDLE (ebr_re, latch addr, mask, wdata) -> READ (merge wdata[7:0] or wdata[15:0] into ebr_rdata at the selected lane, register it) -> MERGE (ebr_we=1 with merged word) -> DONE -> IDLE.
REQ-017 In DONE, the CPU request still present on the bus SHALL NOT be re-sampled.
REQ-018 ldr_ready SHALL equal (state==IDLE) & ~cpu_memread & ~cpu_memwrite; the CPU has strict priority.
REQ-019 A loader handshake (ldr_valid & ldr_ready) SHALL issue ebr_we with ldr_addr and ldr_wdata in the same cycle.
REQ-020 ebr_re and ebr_we SHALL never be high in the same cycle, and each SHALL be high for at most one cycle per access.

Reset
REQ-021 On rst: state=IDLE, cpu_rdata=0, led=0, clk_stall=0, ebr_re=0, ebr_we=0, ldr_ready=0.
REQ-022 rst asserted mid-RMW SHALL abandon the operation with no EBR write issued.

Configuration
REQ-023 With macro EBR_MEM_CTRL_LED_EN defined, accesses with cpu_addr==LED_ADDR SHALL hit the LED register.
REQ-024 Under EBR_MEM_CTRL_LED_EN, a store SHALL load led from cpu_wdata[7:0] in one cycle with no stall and no EBR access.
REQ-025 Under EBR_MEM_CTRL_LED_EN, a load SHALL return {24'b0, led} via IDLE -> DONE with no EBR access.
REQ-026 Without EBR_MEM_CTRL_LED_EN, led SHALL be tied to 0 and LED_ADDR SHALL be decoded as an ordinary EBR address.

Verification
REQ-027 EBR word 5 = 32'h8091A2B3; lb at byte addr 0x16 (sign_mask 4'b1001) -> clk_stall high 2 cycles, cpu_rdata=32'hFFFFFF91; lbu at the same address (4'b0001) -> 32'h00000091.
REQ-028 Word 5 = 32'h8091A2B3; sh 16'h1234 at 0x16 (4'b0011) -> ebr_re, then ebr_we with 32'h1234A2B3 2 cycles later, clk_stall high 3 cycles.
REQ-029 sw 32'hDEADBEEF at 0x20 -> ebr_we same cycle at word 8, clk_stall never high.
REQ-030 ldr_valid held during a CPU lw -> ldr_ready low until the FSM returns to IDLE with no CPU request, then the loader write is issued.
REQ-031 rst pulsed in the MERGE-preceding READ cycle of an sb -> no ebr_we, all outputs at reset values next cycle.
REQ-032 With EBR_MEM_CTRL_LED_EN: sw 32'h000000A5 to 0x2000 -> led=8'hA5 next cycle, no ebr_we; without it -> ebr_we at word 0x000.
